uart_loopback_bist: RTL and testbench

Synthesizable built-in self-test master for the APB UART (top) wired in tx->rx loopback. It replaces the behavioural pattern with an on-chip engine. The engine drives the UART's bus-master inputs (transfer, write_read, addr, wdata), programs the baud divider and streams a parametrised byte pattern. Each byte is read back on IRQ and compared, with a pass/fail verdict and error statistics reported to the SoC.

---
 rtl/uart_bist_pkg.sv | 44 ++++
 rtl/bist_pattern_gen.sv | 46 ++++
 rtl/uart_loopback_bist.sv | 179 +++++++++++++++++
 tb/tb_uart_loopback_bist.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_bist_pkg.sv
// Shared types and constants for the UART loopback self-test engine.
// Latency: n/a (declarations only); backpressure: n/a.
package uart_bist_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CFG_BAUD,
      ST_CFG_CTRL,
      ST_SEND,
      ST_WAIT_IRQ,
      ST_READ,
      ST_WAIT_CLR,
      ST_DONE
   } bist_state_t;

   typedef enum logic [1:0] {
      MODE_INC   = 2'd0,
      MODE_LFSR  = 2'd1,
      MODE_WALK  = 2'd2,
      MODE_CONST = 2'd3
   } pat_mode_t;

   localparam logic [31:0] UART_ADDR_BAUD   = 32'h0000_0000;
   localparam logic [31:0] UART_ADDR_CTRL   = 32'h0000_0004;
   localparam logic [31:0] UART_ADDR_TXDATA = 32'h0000_0008;
   localparam logic [31:0] UART_ADDR_RXDATA = 32'h0000_000C;

   localparam int CTRL_UART_EN    = 0;
   localparam int CTRL_RX_IRQ_EN  = 1;
   localparam logic [31:0] CTRL_RUN_VAL = (32'd1 << CTRL_UART_EN) | (32'd1 << CTRL_RX_IRQ_EN);

   // Fibonacci feedback taps (bit i set = stage i+1 feeds the XOR), maximal length per width.
   function automatic logic [8:0] lfsr_taps(input int w);
      case (w)
         5:       return 9'h014;
         6:       return 9'h030;
         7:       return 9'h060;
         8:       return 9'h0B8;
         9:       return 9'h110;
         default: return 9'h0B8;
      endcase
   endfunction

endpackage

// File: rtl/bist_pattern_gen.sv
// Test pattern source: load seeds the sequence, advance steps it per the latched mode.
// Latency: new value one cycle after load/advance; backpressure: none, steps only when told.
module bist_pattern_gen
   import uart_bist_pkg::*;
#(
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              load,
   input  logic              advance,
   input  logic [1:0]        mode,
   input  logic [DATA_W-1:0] seed,
   output logic [DATA_W-1:0] pat
);

   localparam logic [DATA_W-1:0] TAPS = DATA_W'(lfsr_taps(DATA_W));
   localparam logic [DATA_W-1:0] ONE  = DATA_W'(1);

   pat_mode_t         mode_q;
   logic [DATA_W-1:0] pat_next;

   always_comb begin
      pat_next = pat;
      case (mode_q)
         MODE_INC:  pat_next = pat + ONE;
         MODE_LFSR: pat_next = {pat[DATA_W-2:0], ^(pat & TAPS)};
         MODE_WALK: pat_next = {pat[DATA_W-2:0], pat[DATA_W-1]};
         default:   pat_next = pat;
      endcase
   end

   // An all-zero LFSR or walking-one would lock up, so a zero seed starts at 1.
   always_ff @(posedge clk) begin
      if (reset) begin
         mode_q <= MODE_INC;
         pat    <= '0;
      end else if (load) begin
         mode_q <= pat_mode_t'(mode);
         pat    <= ((mode == MODE_LFSR || mode == MODE_WALK) && seed == '0) ? ONE : seed;
      end else if (advance) begin
         pat    <= pat_next;
      end
   end

endmodule

// File: rtl/uart_loopback_bist.sv
// Loopback self-test master: configures the UART, streams a pattern, reads each char back on IRQ.
// Latency: ACCESS_LAT+1 cycles per bus access, one access at a time; backpressure: stalls on IRQ with timeout.
module uart_loopback_bist
   import uart_bist_pkg::*;
#(
   parameter int          DATA_W      = 8,
   parameter int          NUM_WORDS   = 16,
   parameter int          ACCESS_LAT  = 2,
   parameter int          TIMEOUT_CYC = 200000,
   parameter logic [31:0] ADDR_BAUD   = UART_ADDR_BAUD,
   parameter logic [31:0] ADDR_CTRL   = UART_ADDR_CTRL,
   parameter logic [31:0] ADDR_TXDATA = UART_ADDR_TXDATA,
   parameter logic [31:0] ADDR_RXDATA = UART_ADDR_RXDATA
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [1:0]        mode,
   input  logic [DATA_W-1:0] seed,
   input  logic [15:0]       baud_div,
   output logic              transfer,
   output logic              write_read,
   output logic [31:0]       addr,
   output logic [31:0]       wdata,
   input  logic [31:0]       rdata,
   input  logic              IRQ,
   output logic              busy,
   output logic              done,
   output logic              pass,
   output logic              timeout,
   output logic [15:0]       err_count,
   output logic [15:0]       first_err_idx
);

   localparam int          LAT      = (ACCESS_LAT < 1) ? 1 : ACCESS_LAT;
   localparam logic [15:0] LAST_IDX = 16'(NUM_WORDS - 1);

   bist_state_t       state, state_nxt;
   logic              acc_pend;
   logic [7:0]        lat_cnt;
   logic [31:0]       tmo_cnt;
   logic [15:0]       idx;
   logic [15:0]       baud_q;
   logic [DATA_W-1:0] pat;
   logic              bus_state, acc_done, tmo_hit, mismatch, tmo_abort;
   logic              pat_load, pat_adv;
   logic              rdata_unused;

   assign rdata_unused = ^rdata[31:DATA_W];

   bist_pattern_gen #(.DATA_W(DATA_W)) u_pat (
      .clk     (clk),
      .reset   (reset),
      .load    (pat_load),
      .advance (pat_adv),
      .mode    (mode),
      .seed    (seed),
      .pat     (pat)
   );

   assign bus_state = state inside {ST_CFG_BAUD, ST_CFG_CTRL, ST_SEND, ST_READ};
   assign acc_done  = bus_state && acc_pend && (lat_cnt == 8'(LAT));
   assign tmo_hit   = (tmo_cnt == 32'(TIMEOUT_CYC - 1));
   assign tmo_abort = tmo_hit && (((state == ST_WAIT_IRQ) && !IRQ) || ((state == ST_WAIT_CLR) && IRQ));
   assign mismatch  = (state == ST_READ) && acc_done && (rdata[DATA_W-1:0] != pat);
   // Gated by reset so a reset landing on an issue cycle never leaks a request.
   assign transfer  = bus_state && !acc_pend && !reset;
   assign busy      = !(state inside {ST_IDLE, ST_DONE});
   assign done      = (state == ST_DONE);

   always_comb begin
      state_nxt  = state;
      write_read = 1'b0;
      addr       = '0;
      wdata      = '0;
      pat_load   = 1'b0;
      pat_adv    = 1'b0;
      case (state)
         ST_IDLE: begin
            if (start) begin
               state_nxt = ST_CFG_BAUD;
               pat_load  = 1'b1;
            end
         end
         ST_CFG_BAUD: begin
            write_read = 1'b1;
            addr       = ADDR_BAUD;
            wdata      = {16'h0000, baud_q};
            if (acc_done) state_nxt = ST_CFG_CTRL;
         end
         ST_CFG_CTRL: begin
            write_read = 1'b1;
            addr       = ADDR_CTRL;
            wdata      = CTRL_RUN_VAL;
            if (acc_done) state_nxt = ST_SEND;
         end
         ST_SEND: begin
            write_read = 1'b1;
            addr       = ADDR_TXDATA;
            wdata      = 32'(pat);
            if (acc_done) state_nxt = ST_WAIT_IRQ;
         end
         ST_WAIT_IRQ: begin
            if (IRQ)          state_nxt = ST_READ;
            else if (tmo_hit) state_nxt = ST_DONE;
         end
         ST_READ: begin
            addr = ADDR_RXDATA;
            if (acc_done) state_nxt = ST_WAIT_CLR;
         end
         ST_WAIT_CLR: begin
            if (!IRQ) begin
               if (idx == LAST_IDX) begin
                  state_nxt = ST_DONE;
               end else begin
                  state_nxt = ST_SEND;
                  pat_adv   = 1'b1;
               end
            end else if (tmo_hit) begin
               state_nxt = ST_DONE;
            end
         end
         ST_DONE: state_nxt = ST_IDLE;
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state         <= ST_IDLE;
         acc_pend      <= 1'b0;
         lat_cnt       <= '0;
         tmo_cnt       <= '0;
         idx           <= '0;
         baud_q        <= '0;
         pass          <= 1'b0;
         timeout       <= 1'b0;
         err_count     <= '0;
         first_err_idx <= 16'hFFFF;
      end else begin
         state <= state_nxt;

         if (transfer) begin
            acc_pend <= 1'b1;
            lat_cnt  <= 8'd1;
         end else if (acc_done) begin
            acc_pend <= 1'b0;
            lat_cnt  <= '0;
         end else if (acc_pend) begin
            lat_cnt  <= lat_cnt + 8'd1;
         end

         // Timer restarts whenever a wait state is entered from a bus state.
         if (state inside {ST_WAIT_IRQ, ST_WAIT_CLR}) tmo_cnt <= tmo_cnt + 32'd1;
         else                                         tmo_cnt <= '0;

         if (state == ST_IDLE && start) begin
            baud_q        <= baud_div;
            idx           <= '0;
            pass          <= 1'b0;
            timeout       <= 1'b0;
            err_count     <= '0;
            first_err_idx <= 16'hFFFF;
         end

         if (pat_adv) idx <= idx + 16'd1;

         if (mismatch) begin
            if (err_count != 16'hFFFF)     err_count     <= err_count + 16'd1;
            if (first_err_idx == 16'hFFFF) first_err_idx <= idx;
         end

         if (tmo_abort) timeout <= 1'b1;

         if (state == ST_DONE) pass <= (err_count == 16'd0) && !timeout;
      end
   end

endmodule

// File: tb/tb_uart_loopback_bist.sv
// Bench for uart_loopback_bist: behavioural UART loopback responder plus directed/random runs.
// Latency: n/a; backpressure: responder raises IRQ after a random delay, or never when blocked.
module tb_uart_loopback_bist;

   localparam int DATA_W      = 8;
   localparam int NUM_WORDS   = 16;
   localparam int ACCESS_LAT  = 2;
   localparam int TIMEOUT_CYC = 50;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic [1:0]  mode = 2'd0;
   logic [7:0]  seed = 8'h00;
   logic [15:0] baud_div = 16'h0000;
   logic        transfer, write_read;
   logic [31:0] addr, wdata;
   logic [31:0] rdata = 32'h0;
   logic        IRQ = 1'b0;
   logic        busy, done, pass, timeout;
   logic [15:0] err_count, first_err_idx;

   int vec  = 0;
   int miss = 0;

   uart_loopback_bist #(
      .DATA_W(DATA_W), .NUM_WORDS(NUM_WORDS), .ACCESS_LAT(ACCESS_LAT), .TIMEOUT_CYC(TIMEOUT_CYC)
   ) dut (
      .clk(clk), .reset(reset), .start(start), .mode(mode), .seed(seed), .baud_div(baud_div),
      .transfer(transfer), .write_read(write_read), .addr(addr), .wdata(wdata), .rdata(rdata),
      .IRQ(IRQ), .busy(busy), .done(done), .pass(pass), .timeout(timeout),
      .err_count(err_count), .first_err_idx(first_err_idx)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
   } acc_t;

   acc_t        log_q[$];
   bit          irq_block = 1'b0;
   logic [15:0] flip_mask = 16'h0;
   int          cyc = 0, done_cnt = 0, done_cyc = 0, tx_cyc = -1, tx_idx = 0, proto_err = 0;
   int          rd_cnt = 0, irq_cd = 0, pend = 0;
   logic [7:0]  rx_val = 8'h0;
   logic [31:0] hold_addr = 32'h0;

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   // UART in loopback: TXDATA write echoes into RX after a delay; RXDATA read clears IRQ.
   initial forever begin
      @(negedge clk);
      if (reset) begin
         IRQ = 1'b0; irq_cd = 0; rd_cnt = 0; pend = 0;
         continue;
      end
      if (done) begin done_cnt++; done_cyc = cyc; end
      if (pend > 0) begin
         if (transfer || addr !== hold_addr) proto_err++;
         pend--;
      end
      if (rd_cnt > 0) begin
         rd_cnt--;
         rdata = (rd_cnt == 0) ? {24'h0, rx_val} : $urandom;
      end else begin
         rdata = $urandom;
      end
      if (irq_cd > 0) begin
         irq_cd--;
         if (irq_cd == 0 && !irq_block) IRQ = 1'b1;
      end
      if (transfer) begin
         log_q.push_back({write_read, addr, wdata});
         pend = ACCESS_LAT;
         hold_addr = addr;
         if (write_read && addr == 32'h8) begin
            rx_val = wdata[7:0] ^ {7'b0, (tx_idx < 16) ? flip_mask[tx_idx] : 1'b0};
            tx_idx++;
            irq_cd = $urandom_range(1, 12);
            if (tx_cyc < 0) tx_cyc = cyc;
         end
         if (!write_read && addr == 32'hC) begin
            IRQ = 1'b0;
            rd_cnt = ACCESS_LAT;
         end
      end
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vec++;
      assert (obs === exp) else begin
         miss++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Expected i-th character straight from the pattern definitions.
   function automatic logic [7:0] exp_pat(input logic [1:0] m, input logic [7:0] s, input int i);
      int v = (s == 0 && (m == 2'd1 || m == 2'd2)) ? 1 : int'(s);
      case (m)
         2'd0: return 8'((int'(s) + i) % 256);
         2'd2: return 8'(((v << (i % 8)) | (v >> (8 - i % 8))) & 255);
         2'd3: return s;
         default: begin
            for (int k = 0; k < i; k++)
               v = ((v << 1) & 255) | (((v >> 7) ^ (v >> 5) ^ (v >> 4) ^ (v >> 3)) & 1);
            return 8'(v);
         end
      endcase
   endfunction

   function automatic logic [31:0] tx_data(input int k);
      if (log_q.size() > 2 + 2 * k) return log_q[2 + 2 * k].wdata;
      return 32'hDEAD_BEEF;
   endfunction

   task automatic pulse_start();
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic run(input string tag, input logic [1:0] m, input logic [7:0] s,
                      input logic [15:0] fm, input bit blk, input bit again);
      int n_exp, nerr, ferr;
      logic        e_we;
      logic [31:0] e_addr, e_wd;
      mode = m; seed = s; baud_div = 16'($urandom); flip_mask = fm; irq_block = blk;
      log_q.delete(); done_cnt = 0; tx_idx = 0; tx_cyc = -1; proto_err = 0;
      pulse_start();
      for (int c = 0; c < 4000 && done_cnt == 0; c++) begin
         @(posedge clk); #1;
         start = again && (c == 20 || c == 60);
      end
      start = 1'b0;
      check({tag, " done_seen"}, 64'(done_cnt > 0), 64'd1);
      repeat (3) @(posedge clk);
      #1;
      nerr = 0; ferr = 16'hFFFF;
      for (int i = NUM_WORDS - 1; i >= 0; i--)
         if (!blk && fm[i]) begin nerr++; ferr = i; end
      n_exp = blk ? 3 : 2 + 2 * NUM_WORDS;
      check({tag, " done_pulses"}, 64'(done_cnt), 64'd1);
      check({tag, " busy"}, 64'(busy), 64'd0);
      check({tag, " n_access"}, 64'(log_q.size()), 64'(n_exp));
      check({tag, " protocol"}, 64'(proto_err), 64'd0);
      for (int i = 0; i < n_exp && i < log_q.size(); i++) begin
         if (i == 0)               begin e_we = 1'b1; e_addr = 32'h0; e_wd = {16'h0, baud_div}; end
         else if (i == 1)          begin e_we = 1'b1; e_addr = 32'h4; e_wd = 32'h3; end
         else if ((i - 2) % 2 == 0) begin e_we = 1'b1; e_addr = 32'h8; e_wd = {24'h0, exp_pat(m, s, (i - 2) / 2)}; end
         else                      begin e_we = 1'b0; e_addr = 32'hC; e_wd = 32'h0; end
         check($sformatf("%s acc%0d", tag, i), {31'h0, log_q[i].we, log_q[i].addr}, {31'h0, e_we, e_addr});
         if (e_we) check($sformatf("%s wdata%0d", tag, i), 64'(log_q[i].wdata), 64'(e_wd));
      end
      check({tag, " err_count"}, 64'(err_count), 64'(nerr));
      check({tag, " first_err_idx"}, 64'(first_err_idx), 64'(ferr));
      check({tag, " timeout"}, 64'(timeout), 64'(blk));
      check({tag, " pass"}, 64'(pass), 64'(nerr == 0 && !blk));
      if (blk)
         check({tag, " tmo_latency"},
               64'((done_cyc - tx_cyc) >= TIMEOUT_CYC && (done_cyc - tx_cyc) <= TIMEOUT_CYC + ACCESS_LAT + 3), 64'd1);
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, " busy"}, 64'(busy), 64'd0);
      check({tag, " done"}, 64'(done), 64'd0);
      check({tag, " pass"}, 64'(pass), 64'd0);
      check({tag, " timeout"}, 64'(timeout), 64'd0);
      check({tag, " err_count"}, 64'(err_count), 64'd0);
      check({tag, " first_err_idx"}, 64'(first_err_idx), 64'hFFFF);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, vectors=%0d", vec);
      $fatal(1);
   end

   initial begin
      reset = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check_reset_vals("reset");
      check("reset transfer", 64'(transfer), 64'd0);
      check("reset bus", {31'h0, write_read, addr}, 64'd0);
      reset = 1'b0;
      @(posedge clk); #1;

      run("inc", 2'd0, 8'h10, 16'h0000, 1'b0, 1'b0);
      run("lfsr", 2'd1, 8'h00, 16'h0000, 1'b0, 1'b0);
      check("lfsr tx0", 64'(tx_data(0)), 64'h01);
      check("lfsr tx1", 64'(tx_data(1)), 64'h02);
      check("lfsr tx2", 64'(tx_data(2)), 64'h04);
      check("lfsr tx3", 64'(tx_data(3)), 64'h08);
      run("flip", 2'd0, 8'($urandom), 16'h0220, 1'b0, 1'b0);
      check("flip err2", 64'(err_count), 64'd2);
      check("flip first5", 64'(first_err_idx), 64'd5);
      for (int r = 0; r < 3; r++)
         run($sformatf("rnd%0d", r), 2'($urandom), 8'($urandom), 16'($urandom), 1'b0, 1'b0);
      run("tmo", 2'd0, 8'h5A, 16'h0000, 1'b1, 1'b0);

      // Reset while waiting for IRQ, then a clean run.
      irq_block = 1'b1; log_q.delete(); done_cnt = 0;
      pulse_start();
      for (int c = 0; c < 200 && log_q.size() < 3; c++) @(posedge clk);
      check("rst_wait reached_tx", 64'(log_q.size() >= 3), 64'd1);
      repeat (5) @(posedge clk);
      #1;
      reset = 1'b1;
      #1;
      check("rst_wait transfer", 64'(transfer), 64'd0);
      @(posedge clk); #1;
      check_reset_vals("rst_wait");
      reset = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      check("rst_wait no_done", 64'(done_cnt), 64'd0);
      run("after_rst", 2'd2, 8'h00, 16'h0000, 1'b0, 1'b0);

      // Reset on a cycle that is issuing a request.
      pulse_start();
      for (int c = 0; c < 20 && !transfer; c++) begin @(posedge clk); #1; end
      reset = 1'b1;
      #1;
      check("rst_xfer transfer", 64'(transfer), 64'd0);
      @(posedge clk); #1;
      reset = 1'b0;
      check("rst_xfer busy", 64'(busy), 64'd0);

      // start together with reset: reset wins.
      reset = 1'b1; start = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0; start = 1'b0;
      @(posedge clk); #1;
      check("rst_start busy", 64'(busy), 64'd0);

      run("restart_ignored", 2'd3, 8'($urandom), 16'h0000, 1'b0, 1'b1);

      $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
      $finish;
   end

endmodule
